// File: rtl/ic_arb_2to1.sv
// Two-requester arbiter that shares one req/gnt/recv/ack target port between m0 and m1.
// Latency: one cycle of arbitration in IDLE, then the target's gnt and response pass through combinationally.
// Backpressure: only the owner sees the target's s_gnt and drives s_ack; the other requester waits with gnt/recv low.
`timescale 1ns/1ps
module ic_arb_2to1 #(
   parameter bit FIXED_PRIO = 1'b0,
   parameter bit M1_FIRST   = 1'b0
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   // requester 0
   input  logic        m0_req,
   input  logic        m0_wen,
   input  logic [3:0]  m0_strb,
   input  logic [31:0] m0_wdata,
   input  logic [31:0] m0_addr,
   output logic        m0_gnt,
   output logic        m0_recv,
   input  logic        m0_ack,
   output logic        m0_error,
   output logic [31:0] m0_rdata,
   // requester 1
   input  logic        m1_req,
   input  logic        m1_wen,
   input  logic [3:0]  m1_strb,
   input  logic [31:0] m1_wdata,
   input  logic [31:0] m1_addr,
   output logic        m1_gnt,
   output logic        m1_recv,
   input  logic        m1_ack,
   output logic        m1_error,
   output logic [31:0] m1_rdata,
   // shared target
   output logic        s_req,
   output logic        s_wen,
   output logic [3:0]  s_strb,
   output logic [31:0] s_wdata,
   output logic [31:0] s_addr,
   input  logic        s_gnt,
   input  logic        s_recv,
   output logic        s_ack,
   input  logic        s_error,
   input  logic [31:0] s_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   owner;       // 0 = m0, 1 = m1
   logic   owner_nxt;
   logic   last;        // port that won the most recent granted transfer
   logic   last_nxt;
   logic   pick;
   logic   own_req;
   logic   own_ack;
   logic   in_req;
   logic   in_rsp;

   // Outputs are forced low while reset is held, even before the first reset edge.
   assign in_req  = g_resetn && (state == REQ);
   assign in_rsp  = g_resetn && (state == RSP);
   assign own_req = owner ? m1_req : m0_req;
   assign own_ack = owner ? m1_ack : m0_ack;

   // Winner selection: a lone requester wins; contention goes to m0 or to the port that did not win last.
   always_comb begin
      pick = 1'b0;
      if (m0_req && m1_req) begin
         pick = FIXED_PRIO ? 1'b0 : ~last;
      end else begin
         pick = m1_req;
      end
   end

   // Next-state logic: one outstanding transaction, owner fixed from arbitration until the response completes.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               owner_nxt = pick;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (!own_req) begin
               // owner withdrew before gnt: abandon without touching the RR pointer
               state_nxt = IDLE;
            end else if (s_gnt) begin
               last_nxt  = owner;
               state_nxt = RSP;
            end
         end
         RSP: begin
            if (s_recv && own_ack) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, owner and round-robin pointer registers with synchronous reset.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= M1_FIRST ? 1'b0 : 1'b1;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
      end
   end

   // Request path: owner's payload to the target in REQ, target gnt back to the owner only.
   always_comb begin
      s_req   = 1'b0;
      s_wen   = 1'b0;
      s_strb  = 4'h0;
      s_wdata = 32'h0;
      s_addr  = 32'h0;
      m0_gnt  = 1'b0;
      m1_gnt  = 1'b0;
      if (in_req) begin
         s_req = own_req;
         if (owner) begin
            s_wen   = m1_wen;
            s_strb  = m1_strb;
            s_wdata = m1_wdata;
            s_addr  = m1_addr;
            m1_gnt  = s_gnt;
         end else begin
            s_wen   = m0_wen;
            s_strb  = m0_strb;
            s_wdata = m0_wdata;
            s_addr  = m0_addr;
            m0_gnt  = s_gnt;
         end
      end
   end

   // Response path: target response to the owner in RSP, owner's ack back to the target.
   always_comb begin
      m0_recv  = 1'b0;
      m0_error = 1'b0;
      m0_rdata = 32'h0;
      m1_recv  = 1'b0;
      m1_error = 1'b0;
      m1_rdata = 32'h0;
      s_ack    = 1'b0;
      if (in_rsp) begin
         s_ack = own_ack;
         if (owner) begin
            m1_recv  = s_recv;
            m1_error = s_error;
            m1_rdata = s_rdata;
         end else begin
            m0_recv  = s_recv;
            m0_error = s_error;
            m0_rdata = s_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ic_arb_2to1.sv
// Directed bench for ic_arb_2to1: a round-robin instance and a fixed-priority instance share all inputs.
// Latency: inputs change 1ns after the rising edge, outputs are compared 1ns later.
// Backpressure: target gnt/recv and requester acks are driven by hand per step.
`timescale 1ns/1ps
module tb_ic_arb_2to1;

   logic        g_clk;
   logic        g_resetn;
   logic        m0_req, m0_wen, m0_ack;
   logic [3:0]  m0_strb;
   logic [31:0] m0_wdata, m0_addr;
   logic        m1_req, m1_wen, m1_ack;
   logic [3:0]  m1_strb;
   logic [31:0] m1_wdata, m1_addr;
   logic        s_gnt, s_recv, s_error;
   logic [31:0] s_rdata;

   // round-robin instance outputs
   logic        m0_gnt, m0_recv, m0_error;
   logic [31:0] m0_rdata;
   logic        m1_gnt, m1_recv, m1_error;
   logic [31:0] m1_rdata;
   logic        s_req, s_wen, s_ack;
   logic [3:0]  s_strb;
   logic [31:0] s_wdata, s_addr;

   // fixed-priority instance outputs
   logic        fp_m0_gnt, fp_m0_recv, fp_m0_error;
   logic [31:0] fp_m0_rdata;
   logic        fp_m1_gnt, fp_m1_recv, fp_m1_error;
   logic [31:0] fp_m1_rdata;
   logic        fp_s_req, fp_s_wen, fp_s_ack;
   logic [3:0]  fp_s_strb;
   logic [31:0] fp_s_wdata, fp_s_addr;

   int checks   = 0;
   int failures = 0;

   ic_arb_2to1 u_rr (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .m0_req(m0_req), .m0_wen(m0_wen), .m0_strb(m0_strb), .m0_wdata(m0_wdata), .m0_addr(m0_addr),
      .m0_gnt(m0_gnt), .m0_recv(m0_recv), .m0_ack(m0_ack), .m0_error(m0_error), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wen(m1_wen), .m1_strb(m1_strb), .m1_wdata(m1_wdata), .m1_addr(m1_addr),
      .m1_gnt(m1_gnt), .m1_recv(m1_recv), .m1_ack(m1_ack), .m1_error(m1_error), .m1_rdata(m1_rdata),
      .s_req(s_req), .s_wen(s_wen), .s_strb(s_strb), .s_wdata(s_wdata), .s_addr(s_addr),
      .s_gnt(s_gnt), .s_recv(s_recv), .s_ack(s_ack), .s_error(s_error), .s_rdata(s_rdata)
   );

   ic_arb_2to1 #(.FIXED_PRIO(1'b1)) u_fp (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .m0_req(m0_req), .m0_wen(m0_wen), .m0_strb(m0_strb), .m0_wdata(m0_wdata), .m0_addr(m0_addr),
      .m0_gnt(fp_m0_gnt), .m0_recv(fp_m0_recv), .m0_ack(m0_ack), .m0_error(fp_m0_error), .m0_rdata(fp_m0_rdata),
      .m1_req(m1_req), .m1_wen(m1_wen), .m1_strb(m1_strb), .m1_wdata(m1_wdata), .m1_addr(m1_addr),
      .m1_gnt(fp_m1_gnt), .m1_recv(fp_m1_recv), .m1_ack(m1_ack), .m1_error(fp_m1_error), .m1_rdata(fp_m1_rdata),
      .s_req(fp_s_req), .s_wen(fp_s_wen), .s_strb(fp_s_strb), .s_wdata(fp_s_wdata), .s_addr(fp_s_addr),
      .s_gnt(s_gnt), .s_recv(s_recv), .s_ack(fp_s_ack), .s_error(s_error), .s_rdata(s_rdata)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge g_clk);
      #1;
   endtask

   task automatic clear_inputs;
      m0_req = 0; m0_wen = 0; m0_strb = 4'h0; m0_wdata = 0; m0_addr = 0; m0_ack = 0;
      m1_req = 0; m1_wen = 0; m1_strb = 4'h0; m1_wdata = 0; m1_addr = 0; m1_ack = 0;
      s_gnt = 0; s_recv = 0; s_error = 0; s_rdata = 0;
   endtask

   task automatic do_reset;
      clear_inputs();
      g_resetn = 0;
      step();
      g_resetn = 1;
   endtask

   int q_rr[$];
   int q_fp[$];
   int fp_m1_gnt_cnt;
   int exp_rr [4] = '{0, 1, 0, 1};

   initial begin
      clear_inputs();
      g_resetn = 0;
      #1;
      chk("rst0_s_req", {31'd0, s_req}, 0);
      chk("rst0_m0_gnt", {31'd0, m0_gnt}, 0);
      step();
      chk("rst_m1_recv", {31'd0, m1_recv}, 0);
      chk("rst_s_ack", {31'd0, s_ack}, 0);
      chk("rst_s_addr", s_addr, 0);
      g_resetn = 1;

      // ---- m0 single read ----
      m0_req = 1; m0_addr = 32'h2000_0010; s_gnt = 1;
      #1;
      chk("rd_idle_gnt", {31'd0, m0_gnt}, 0);
      chk("rd_idle_s_req", {31'd0, s_req}, 0);
      step();
      chk("rd_req_s_req", {31'd0, s_req}, 1);
      chk("rd_req_s_addr", s_addr, 32'h2000_0010);
      chk("rd_req_m0_gnt", {31'd0, m0_gnt}, 1);
      chk("rd_req_m1_gnt", {31'd0, m1_gnt}, 0);
      step();
      m0_req = 0; m0_addr = 0; s_gnt = 0;
      s_recv = 1; s_rdata = 32'hDEAD_BEEF; m0_ack = 1;
      #1;
      chk("rd_rsp_m0_gnt", {31'd0, m0_gnt}, 0);
      chk("rd_rsp_s_req", {31'd0, s_req}, 0);
      chk("rd_rsp_m0_recv", {31'd0, m0_recv}, 1);
      chk("rd_rsp_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("rd_rsp_m1_recv", {31'd0, m1_recv}, 0);
      chk("rd_rsp_s_ack", {31'd0, s_ack}, 1);
      step();
      s_recv = 0; s_rdata = 0; m0_ack = 0;
      #1;
      chk("rd_done_m0_recv", {31'd0, m0_recv}, 0);

      // ---- contention, both instances in lockstep ----
      do_reset();
      m0_req = 1; m0_addr = 32'h0000_0100;
      m1_req = 1; m1_addr = 32'h0000_0200;
      s_gnt = 1; s_recv = 1; s_rdata = 32'h1234_5678; m0_ack = 1; m1_ack = 1;
      fp_m1_gnt_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (m0_gnt && m1_gnt) chk("cont_both_gnt", 1, 0);
         if (m0_gnt) begin
            q_rr.push_back(0);
            chk("cont_addr_m0", s_addr, 32'h0000_0100);
         end
         if (m1_gnt) begin
            q_rr.push_back(1);
            chk("cont_addr_m1", s_addr, 32'h0000_0200);
         end
         if (fp_m0_gnt) q_fp.push_back(0);
         if (fp_m1_gnt) begin
            q_fp.push_back(1);
            fp_m1_gnt_cnt++;
         end
         step();
      end
      chk("rr_cnt", q_rr.size(), 4);
      chk("fp_cnt", q_fp.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_order%0d", i), (i < q_rr.size()) ? q_rr[i] : 32'hFF, exp_rr[i]);
         chk($sformatf("fp_order%0d", i), (i < q_fp.size()) ? q_fp[i] : 32'hFF, 0);
      end
      chk("fp_m1_never", fp_m1_gnt_cnt, 0);

      // ---- target stall, then m1 arrives ----
      do_reset();
      m0_req = 1; m0_addr = 32'h3000_0000;
      m1_addr = 32'h4000_0004;
      step();   // IDLE -> REQ, owner m0
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("stall_s_req%0d", c), {31'd0, s_req}, 1);
         chk($sformatf("stall_gnt%0d", c), {31'd0, m0_gnt}, 0);
         step();
      end
      m1_req = 1;
      #1;
      chk("stall_m1_wait", {31'd0, m1_gnt}, 0);
      chk("stall_owner_addr", s_addr, 32'h3000_0000);
      s_gnt = 1;
      #1;
      chk("stall_m0_gnt", {31'd0, m0_gnt}, 1);
      chk("stall_m1_gnt", {31'd0, m1_gnt}, 0);
      step();
      m0_req = 0; s_gnt = 0; s_recv = 1; m0_ack = 1;
      #1;
      chk("stall_rsp_m0_recv", {31'd0, m0_recv}, 1);
      chk("stall_rsp_m1_gnt", {31'd0, m1_gnt}, 0);
      step();
      s_recv = 0; m0_ack = 0;
      #1;
      chk("stall_idle_m1_gnt", {31'd0, m1_gnt}, 0);
      step();
      s_gnt = 1;
      #1;
      chk("stall_m1_granted", {31'd0, m1_gnt}, 1);
      chk("stall_m1_addr", s_addr, 32'h4000_0004);
      step();

      // ---- response backpressure with error, m1 owner ----
      m1_req = 0; s_gnt = 0; s_recv = 1; s_error = 1; s_rdata = 32'hCAFE_0001; m1_ack = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp_recv%0d", c), {31'd0, m1_recv}, 1);
         chk($sformatf("bp_err%0d", c), {31'd0, m1_error}, 1);
         chk($sformatf("bp_ack%0d", c), {31'd0, s_ack}, 0);
         step();
      end
      m1_ack = 1;
      #1;
      chk("bp_last_recv", {31'd0, m1_recv}, 1);
      chk("bp_last_rdata", m1_rdata, 32'hCAFE_0001);
      chk("bp_s_ack", {31'd0, s_ack}, 1);
      chk("bp_m0_recv", {31'd0, m0_recv}, 0);
      step();
      s_recv = 0; s_error = 0; m1_ack = 0;
      #1;
      chk("bp_idle_recv", {31'd0, m1_recv}, 0);

      // ---- reset while in RSP ----
      m0_req = 1; m0_addr = 32'h5000_0000; s_gnt = 1;
      step();   // -> REQ
      step();   // -> RSP
      m0_req = 0; s_gnt = 0; s_recv = 1; m0_ack = 0;
      #1;
      chk("rr_rsp_recv", {31'd0, m0_recv}, 1);
      g_resetn = 0;
      step();
      g_resetn = 1;
      #1;
      chk("rr_post_recv", {31'd0, m0_recv}, 0);
      chk("rr_post_s_ack", {31'd0, s_ack}, 0);
      chk("rr_post_s_req", {31'd0, s_req}, 0);
      chk("rr_post_gnt", {30'd0, m0_gnt, m1_gnt}, 0);
      s_recv = 0;
      m0_req = 1; m0_addr = 32'h5000_0040; s_gnt = 1;
      step();
      chk("rr_again_s_req", {31'd0, s_req}, 1);
      chk("rr_again_addr", s_addr, 32'h5000_0040);
      chk("rr_again_gnt", {31'd0, m0_gnt}, 1);
      step();
      m0_req = 0; s_gnt = 0; s_recv = 1; m0_ack = 1;
      step();
      s_recv = 0; m0_ack = 0;

      // ---- owner withdraws before gnt ----
      m1_req = 1; m1_addr = 32'h6000_0000;
      step();   // -> REQ owner m1
      #1;
      chk("wd_s_req_up", {31'd0, s_req}, 1);
      m1_req = 0;
      #1;
      chk("wd_s_req_drop", {31'd0, s_req}, 0);
      chk("wd_m1_gnt", {31'd0, m1_gnt}, 0);
      step();
      s_gnt = 1;
      #1;
      chk("wd_idle_s_req", {31'd0, s_req}, 0);
      chk("wd_idle_gnt", {31'd0, m1_gnt}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
